instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch side of the program counter: owns the PC register, issues instruction
//  reads to instruction memory over a req/gnt + rsp handshake, and hands fetched
//  (address, instruction) pairs to decode through a 2-entry buffer.
//  Supports decode back-pressure and branch/jump redirects with flush.
//  Sits between the next-address logic (branch unit) and the decode stage.
// PARAMETERS
//  ADDRESSLENGTH  32          PC and memory address width (bits)
//  INSTRLENGTH    32          instruction word width (bits)
//  RESETVECTOR    32'h0       PC value loaded on reset
//  PCSTEP         4           byte increment between sequential fetches
// PORTS
//  clk            in   1              single clock, rising edge
//  rst_n          in   1              asynchronous, active-low reset
//  redirect       in   1              branch/jump taken this cycle
//  redirectAddr   in   ADDRESSLENGTH  target address for redirect
//  imemReq        out  1              read request valid
//  imemAddr       out  ADDRESSLENGTH  read address (stable while imemReq && !imemGnt)
//  imemGnt        in   1              request accepted this cycle
//  imemRspValid   in   1              read data valid (in order, >=1 cycle after gnt)
//  imemRspData    in   INSTRLENGTH    read data
//  instrValid     out  1              buffer head valid toward decode
//  instrAddr      out  ADDRESSLENGTH  address of head instruction
//  instrData      out  INSTRLENGTH    head instruction word
//  instrReady     in   1              decode accepts head this cycle
// BEHAVIOUR
//  - Reset (async assert): pc=RESETVECTOR, state=REQ, buffer empty, instrValid=0,
//    imemReq=0 in the reset cycle; instrAddr/instrData=0. First request the cycle after release.
//  - At most ONE outstanding memory request. FSM states:
//    REQ : imemReq=1 iff (occupancy + 0) < 2; imemAddr=pc. On imemGnt -> WAIT,
//          reqAddr<=pc, pc<=pc+PCSTEP (wraps modulo 2^ADDRESSLENGTH).
//    WAIT: imemReq=0. On imemRspValid: push {reqAddr, imemRspData} -> REQ.
//    DROP: imemReq=0. On imemRspValid: discard data -> REQ.
//  - Issue rule: request only if buffer has a free slot for the response
//    (occupancy<2 counting the outstanding one); no response is ever dropped for lack of space.
//  - Buffer: 2-entry FIFO, head drives instr*; pop when instrValid&&instrReady.
//    Push and pop in same cycle allowed when full (occupancy unchanged) or empty
//    (no bypass: data appears next cycle; fetch-to-instrValid latency = gnt + rsp + 1).
//  - Redirect (highest priority, any state): buffer flushed (instrValid=0 next
//    cycle), pc<=redirectAddr. If in WAIT, or REQ with imemGnt this cycle -> DROP;
//    if in DROP stays DROP; else -> REQ. A same-cycle pop is ignored (flushed).
//    A response arriving in the redirect cycle is discarded.
//  - imemReq once asserted is held with constant imemAddr until imemGnt, except
//    a redirect may withdraw/change it.
//  - Misaligned redirectAddr is passed through unchanged (alignment is not checked).
// STRUCTURE
//  - Shared package fetch_pkg: typedef enum {FETCH_REQ, FETCH_WAIT, FETCH_DROP}
//    fetch_state_t; typedef struct {addr, instr} fetch_entry_t; RESETVECTOR default.
//  - One sub-module: fetch_buffer (2-entry FIFO, push/pop/flush, count out).
//  - PC register and FSM live in instr_fetch_unit top.
// TESTING
//  - Reset then imemGnt=1, rsp 1 cycle later, instrReady=1 -> instrAddr 0,4,8,0xC
//    in consecutive order, data matches memory model.
//  - instrReady=0 for 10 cycles -> exactly 2 entries buffered, imemReq stays 0,
//    release -> 0x0,0x4 delivered then fetching resumes at 0x8.
//  - Redirect to 0x100 while in WAIT for 0x8 -> response for 0x8 discarded, next
//    instrAddr=0x100, no 0x8 ever reaches decode.
//  - imemGnt held 0 for 5 cycles -> imemReq=1, imemAddr constant at 0x4 throughout.
//  - pc=32'hFFFFFFFC sequential fetch -> next imemAddr=0x0 (wrap).
//  - Assert rst_n=0 mid-WAIT asynchronously -> instrValid=0, imemReq=0 immediately;
//    after release first imemAddr=RESETVECTOR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-side types: FSM state encoding, buffer entry layout and
// default widths / reset vector used by the fetch unit and its buffer.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W  = 32;
  localparam int unsigned FETCH_INSTR_W = 32;
  localparam int unsigned FETCH_PC_STEP = 4;

  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_VECTOR = 32'h0;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  addr;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// 2-entry FIFO between fetch and decode; flush clears it, head is zero when empty.
// Ports: push/push_addr/push_data in, pop, flush, head_* out, count out.
module fetch_buffer #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  output logic          head_valid,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [1:0]    count
);

  logic [AW-1:0] addr_q [2];
  logic [DW-1:0] data_q [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != 2'd2) || do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        addr_q[wr_ptr] <= push_addr;
        data_q[wr_ptr] <= push_data;
        wr_ptr         <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head_valid = (count != 2'd0);
    head_addr  = head_valid ? addr_q[rd_ptr] : '0;
    head_data  = head_valid ? data_q[rd_ptr] : '0;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register plus single-outstanding imem req/gnt/rsp FSM feeding decode
// through fetch_buffer. Ports: redirect*, imem*, instr*; clk, async rst_n.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDRESSLENGTH = FETCH_ADDR_W,
  parameter int unsigned INSTRLENGTH   = FETCH_INSTR_W,
  parameter logic [ADDRESSLENGTH-1:0] RESETVECTOR =
    ADDRESSLENGTH'(FETCH_RESET_VECTOR),
  parameter int unsigned PCSTEP        = FETCH_PC_STEP
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     redirect,
  input  logic [ADDRESSLENGTH-1:0] redirectAddr,
  output logic                     imemReq,
  output logic [ADDRESSLENGTH-1:0] imemAddr,
  input  logic                     imemGnt,
  input  logic                     imemRspValid,
  input  logic [INSTRLENGTH-1:0]   imemRspData,
  output logic                     instrValid,
  output logic [ADDRESSLENGTH-1:0] instrAddr,
  output logic [INSTRLENGTH-1:0]   instrData,
  input  logic                     instrReady
);

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic [ADDRESSLENGTH-1:0] pc;
  logic [ADDRESSLENGTH-1:0] pc_nxt;
  logic [ADDRESSLENGTH-1:0] req_addr;
  logic                     run;
  logic                     accept;
  logic                     push;
  logic                     pop;
  logic [1:0]               count;

  // run holds requests off during the reset cycle and the one after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH_REQ;
      pc       <= RESETVECTOR;
      req_addr <= '0;
      run      <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      run   <= 1'b1;
      if (accept) begin
        req_addr <= pc;
      end
    end
  end

  // In REQ nothing is outstanding, so occupancy alone bounds the issue;
  // it can only fall while waiting for gnt, keeping imemReq stable.
  always_comb begin
    imemReq   = run && (state == FETCH_REQ) && (count < 2'd2);
    imemAddr  = pc;
    accept    = imemReq && imemGnt;
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    unique case (state)
      FETCH_REQ: begin
        if (accept) begin
          state_nxt = FETCH_WAIT;
          pc_nxt    = pc + ADDRESSLENGTH'(PCSTEP);
        end
      end
      FETCH_WAIT: begin
        if (imemRspValid) begin
          push      = 1'b1;
          state_nxt = FETCH_REQ;
        end
      end
      FETCH_DROP: begin
        if (imemRspValid) begin
          state_nxt = FETCH_REQ;
        end
      end
      default: state_nxt = FETCH_REQ;
    endcase
    // A response landing in the redirect cycle retires the outstanding
    // read, so only a still-pending one needs to be dropped later.
    if (redirect) begin
      push   = 1'b0;
      pc_nxt = redirectAddr;
      unique case (1'b1)
        (state == FETCH_REQ): state_nxt = accept ? FETCH_DROP : FETCH_REQ;
        imemRspValid:         state_nxt = FETCH_REQ;
        default:              state_nxt = FETCH_DROP;
      endcase
    end
    pop = instrValid && instrReady && !redirect;
  end

  fetch_buffer #(
    .AW (ADDRESSLENGTH),
    .DW (INSTRLENGTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_addr  (req_addr),
    .push_data  (imemRspData),
    .pop        (pop),
    .flush      (redirect),
    .head_valid (instrValid),
    .head_addr  (instrAddr),
    .head_data  (instrData),
    .count      (count)
  );

endmodule
